// File: rtl/divider_fp_if.sv
// rtl/divider_fp_if.sv - start/busy/ready handshake bundle for the FP divider
interface divider_fp_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        ready;
  logic        busy;
  logic [31:0] Y;

  modport master (output start, output A, output B,
                  input ready, input busy, input Y);
  modport slave  (input start, input A, input B,
                  output ready, output busy, output Y);
endinterface

// File: rtl/divider_fp.sv
// rtl/divider_fp.sv - multi-cycle IEEE-754 single-precision divider, restoring, RNE
module divider_fp #(
  parameter logic [31:0] NAN_VAL = 32'h7F800001,
  parameter int          QBITS   = 26
) (
  input  logic       clk,
  input  logic       rst,
  divider_fp_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLASSIFY, DIVIDE, NORMALIZE, ROUND} state_t;

  state_t state, state_next;

  logic [31:0]       a_reg, b_reg;
  logic              s;
  logic signed [9:0] e;
  logic [QBITS-1:0]  r, d, q;
  logic [4:0]        cnt;
  logic [24:0]       m;
  logic [31:0]       y_reg;
  logic              ready_reg, busy_reg;

  assign bus.Y     = y_reg;
  assign bus.ready = ready_reg;
  assign bus.busy  = busy_reg;

  // Operand classification of the captured operands and the special-case result
  logic [7:0]  a_exp, b_exp;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        sign_res, special;
  logic [31:0] special_y;

  always_comb begin
    a_exp     = a_reg[30:23];
    b_exp     = b_reg[30:23];
    a_zero    = (a_exp == 8'd0);
    b_zero    = (b_exp == 8'd0);
    a_inf     = (a_exp == 8'hFF) && (a_reg[22:0] == 23'd0);
    b_inf     = (b_exp == 8'hFF) && (b_reg[22:0] == 23'd0);
    a_nan     = (a_exp == 8'hFF) && (a_reg[22:0] != 23'd0);
    b_nan     = (b_exp == 8'hFF) && (b_reg[22:0] != 23'd0);
    sign_res  = a_reg[31] ^ b_reg[31];
    special   = 1'b1;
    special_y = NAN_VAL;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_y = NAN_VAL;
    end else if (a_inf || b_zero) begin
      special_y = {sign_res, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      special_y = {sign_res, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  // Normalise the raw quotient and apply round-to-nearest-even
  logic [23:0]       m_pre;
  logic              g_bit, st_bit, inc;
  logic [24:0]       m_rounded;
  logic signed [9:0] e_norm;

  always_comb begin
    if (q[QBITS-1]) begin
      m_pre  = q[QBITS-1 -: 24];
      g_bit  = q[QBITS-25];
      st_bit = q[QBITS-26] | (r != '0);
      e_norm = e;
    end else begin
      m_pre  = q[QBITS-2 -: 24];
      g_bit  = q[QBITS-26];
      st_bit = (r != '0);
      e_norm = e - 10'sd1;
    end
    inc       = g_bit & (st_bit | m_pre[0]);
    m_rounded = {1'b0, m_pre} + {24'd0, inc};
  end

  // Post-rounding renormalisation and overflow/underflow packing
  logic signed [9:0] e_fin;
  logic [22:0]       frac_fin;
  logic [31:0]       round_y;

  always_comb begin
    if (m[24]) begin
      frac_fin = m[23:1];
      e_fin    = e + 10'sd1;
    end else begin
      frac_fin = m[22:0];
      e_fin    = e;
    end
    if (e_fin >= 10'sd255) begin
      round_y = {s, 8'hFF, 23'd0};
    end else if (e_fin <= 10'sd0) begin
      round_y = {s, 31'd0};
    end else begin
      round_y = {s, e_fin[7:0], frac_fin};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state sequencing
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (bus.start) state_next = CLASSIFY;
      CLASSIFY:  state_next = special ? IDLE : DIVIDE;
      DIVIDE:    if (cnt == 5'(QBITS - 1)) state_next = NORMALIZE;
      NORMALIZE: state_next = ROUND;
      ROUND:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath registers and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s         <= 1'b0;
      e         <= '0;
      r         <= '0;
      d         <= '0;
      q         <= '0;
      cnt       <= '0;
      m         <= '0;
      y_reg     <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.A;
            b_reg    <= bus.B;
            busy_reg <= 1'b1;
          end
        end
        CLASSIFY: begin
          if (special) begin
            y_reg     <= special_y;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            s   <= sign_res;
            e   <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
            r   <= {{(QBITS-24){1'b0}}, 1'b1, a_reg[22:0]};
            d   <= {{(QBITS-24){1'b0}}, 1'b1, b_reg[22:0]};
            q   <= '0;
            cnt <= '0;
          end
        end
        DIVIDE: begin
          if (r >= d) begin
            q <= {q[QBITS-2:0], 1'b1};
            r <= (r - d) << 1;
          end else begin
            q <= {q[QBITS-2:0], 1'b0};
            r <= r << 1;
          end
          cnt <= cnt + 5'd1;
        end
        NORMALIZE: begin
          m <= m_rounded;
          e <= e_norm;
        end
        ROUND: begin
          y_reg     <= round_y;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_fp.sv
// tb/tb_divider_fp.sv - self-checking bench for divider_fp
module tb_divider_fp;

  logic clk;
  logic rst;
  divider_fp_if bus();

  divider_fp dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    int          lat;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Exact quotient via wide integer division, then generic RNE to 24 bits.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          output bit special);
    bit s, an, bn, ai, bi, az, bz, up;
    int ea, eb, e, p, sh;
    longint unsigned ma, mb, n, qv, rem, mant, dropped, half;
    logic [7:0] ev;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    special = 1'b1;
    if (an || bn || (az && bz) || (ai && bi)) return 32'h7F800001;
    if (ai || bz) return {s, 8'hFF, 23'h0};
    if (az || bi) return {s, 31'h0};
    special = 1'b0;
    ma  = {40'd0, 1'b1, a[22:0]};
    mb  = {40'd0, 1'b1, b[22:0]};
    n   = ma << 39;
    qv  = n / mb;
    rem = n % mb;
    p   = ((qv >> 39) != 0) ? 39 : 38;
    sh  = p - 23;
    mant    = qv >> sh;
    dropped = qv & ((64'd1 << sh) - 64'd1);
    half    = 64'd1 << (sh - 1);
    up   = (dropped > half) || ((dropped == half) && ((rem != 0) || mant[0]));
    mant = mant + (up ? 64'd1 : 64'd0);
    e    = ea - eb + 127 + (p - 39);
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    ev = e[7:0];
    return {s, ev, mant[22:0]};
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns at the ready cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] y, output int lat, output logic busy_ok);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    busy_ok = (bus.busy === 1'b1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ready === 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    y = bus.Y;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      ex = 8'h00;
    else if (sel == 1) ex = 8'hFF;
    else               ex = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] y, ya, yb, exp_y;
    int lat, ready_cnt;
    logic busy_ok;
    bit sp;

    vt[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 29};
    vt[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 29};
    vt[2]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 29};
    vt[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1};
    vt[4]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1};
    vt[5]  = '{32'h00000000, 32'h00000000, 32'h7F800001, 1};
    vt[6]  = '{32'h7F800000, 32'h7F800000, 32'h7F800001, 1};
    vt[7]  = '{32'h00000000, 32'h40000000, 32'h00000000, 1};
    vt[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7F800001, 1};
    vt[9]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 29};
    vt[10] = '{32'h00800000, 32'h7F000000, 32'h00000000, 29};
    vt[11] = '{32'h80800000, 32'h7F000000, 32'h80000000, 29};
    vt[12] = '{32'h3F800000, 32'h7F800000, 32'h00000000, 1};
    vt[13] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1};
    vt[14] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, bus.ready}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_y", bus.Y, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].a, vt[i].b, y, lat, busy_ok);
      chk($sformatf("vec%0d_y", i), y, vt[i].y);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy", i), {31'd0, busy_ok}, 32'd1);
    end

    // start pulsed mid-operation must be ignored
    @(posedge clk); #1;
    bus.start = 1'b1; bus.A = 32'h40C00000; bus.B = 32'h40000000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    ready_cnt = 0;
    while (lat < 40) begin
      if (lat == 4) begin
        bus.start = 1'b1; bus.A = 32'h3F800000; bus.B = 32'h40400000;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus.ready === 1'b1) break;
    end
    bus.start = 1'b0;
    chk("ignore_y", bus.Y, 32'h40400000);
    chk("ignore_lat", lat, 29);
    @(posedge clk); #1;
    chk("ready_drops", {31'd0, bus.ready}, 32'd0);
    chk("no_pending_busy", {31'd0, bus.busy}, 32'd0);

    // back-to-back: second start during the first ready cycle
    run_op(32'h40C00000, 32'h40000000, ya, lat, busy_ok);
    chk("b2b_first_y", ya, 32'h40400000);
    run_op(32'h3F800000, 32'h3F800000, yb, lat, busy_ok);
    chk("b2b_second_y", yb, 32'h3F800000);
    chk("b2b_second_lat", lat, 29);
    chk("b2b_second_busy", {31'd0, busy_ok}, 32'd1);

    // reset in the middle of DIVIDE
    bus.start = 1'b1; bus.A = 32'h40C00000; bus.B = 32'h40000000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_y", bus.Y, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_cnt = 0;
    for (int c = 0; c < 35; c++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) ready_cnt++;
    end
    chk("midrst_no_ready", ready_cnt, 0);
    run_op(32'h40C00000, 32'h40000000, y, lat, busy_ok);
    chk("post_rst_y", y, 32'h40400000);
    chk("post_rst_lat", lat, 29);

    // randomized operands against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = rand_fp();
      rb = rand_fp();
      exp_y = ref_div(ra, rb, sp);
      run_op(ra, rb, y, lat, busy_ok);
      chk($sformatf("rand%0d_y(%h/%h)", i, ra, rb), y, exp_y);
      chk($sformatf("rand%0d_lat", i), lat, sp ? 1 : 29);
      chk($sformatf("rand%0d_busy", i), {31'd0, busy_ok}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
